// File: rtl/writeback_unit.sv
// Writeback arbiter: a load wins the register-file write port, ALU results wait in a small FIFO, and an 8-entry pending scoreboard tracks outstanding writes.
// Optional forward path compiled in with `define WB_BYPASS_EN.
module writeback_unit #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [2:0]  alu_rd,
    input  logic [31:0] alu_value,
    output logic        alu_ready,
    input  logic        load_valid,
    input  logic [2:0]  load_rd,
    input  logic [31:0] load_value,
    input  logic        issue_valid,
    input  logic [2:0]  issue_rd,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rs1_fwd_en,
    output logic        rs2_fwd_en,
    output logic [31:0] fwd_value,
    output logic        reg_write_en,
    output logic [2:0]  rd,
    output logic [31:0] rd_value
);

    // Storage is sized for the largest legal depth; only QDEPTH entries are used.
    logic [2:0]  q_rd_q  [4];
    logic [31:0] q_val_q [4];
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  pending_q, pending_d;
    logic        wen_q, wen_d;
    logic [2:0]  rd_q, rd_d;
    logic [31:0] rd_value_q, rd_value_d;

    logic        alu_acc_s;
    logic        deq_s;
    logic        enq_s;
    logic        alu_taken_s;
    logic        hit1_s;
    logic        hit2_s;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign alu_ready = (count_q < 3'(QDEPTH));
    assign alu_acc_s = alu_valid && alu_ready;

    // Write-source selection, queue bookkeeping and scoreboard next state.
    always_comb begin
        wen_d       = 1'b0;
        rd_d        = 3'd0;
        rd_value_d  = 32'd0;
        deq_s       = 1'b0;
        alu_taken_s = 1'b0;
        if (load_valid && (load_rd != 3'd0)) begin
            wen_d      = 1'b1;
            rd_d       = load_rd;
            rd_value_d = load_value;
        end else if (count_q != 3'd0) begin
            wen_d      = 1'b1;
            rd_d       = q_rd_q[head_q];
            rd_value_d = q_val_q[head_q];
            deq_s      = 1'b1;
        end else if (alu_acc_s && (alu_rd != 3'd0)) begin
            wen_d       = 1'b1;
            rd_d        = alu_rd;
            rd_value_d  = alu_value;
            alu_taken_s = 1'b1;
        end else begin
            wen_d = 1'b0;
        end

        enq_s  = alu_acc_s && (alu_rd != 3'd0) && !alu_taken_s;
        head_d = deq_s ? next_ptr(head_q) : head_q;
        tail_d = enq_s ? next_ptr(tail_q) : tail_q;

        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // Issue is applied after the clear so a same-cycle set wins.
        pending_d = pending_q;
        if (wen_d) begin
            pending_d[rd_d] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (issue_valid && (issue_rd != 3'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
    end

    // Control state: queue pointers, scoreboard and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            count_q    <= 3'd0;
            pending_q  <= 8'd0;
            wen_q      <= 1'b0;
            rd_q       <= 3'd0;
            rd_value_q <= 32'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            wen_q      <= wen_d;
            rd_q       <= rd_d;
            rd_value_q <= rd_value_d;
        end
    end

    // Queue payload storage, written at the tail on enqueue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                q_rd_q[i]  <= 3'd0;
                q_val_q[i] <= 32'd0;
            end
        end else if (enq_s) begin
            q_rd_q[tail_q]  <= alu_rd;
            q_val_q[tail_q] <= alu_value;
        end else begin
            q_rd_q[tail_q]  <= q_rd_q[tail_q];
            q_val_q[tail_q] <= q_val_q[tail_q];
        end
    end

    assign reg_write_en = wen_q;
    assign rd           = rd_q;
    assign rd_value     = rd_value_q;

    assign hit1_s = wen_q && (rd_q == rs1) && (rs1 != 3'd0);
    assign hit2_s = wen_q && (rd_q == rs2) && (rs2 != 3'd0);

`ifdef WB_BYPASS_EN
    assign rs1_busy   = (rs1 != 3'd0) && pending_q[rs1];
    assign rs2_busy   = (rs2 != 3'd0) && pending_q[rs2];
    assign rs1_fwd_en = hit1_s;
    assign rs2_fwd_en = hit2_s;
    assign fwd_value  = rd_value_q;
`else
    // Without forwarding, a value being written this cycle is still unreadable.
    assign rs1_busy   = ((rs1 != 3'd0) && pending_q[rs1]) || hit1_s;
    assign rs2_busy   = ((rs2 != 3'd0) && pending_q[rs2]) || hit2_s;
    assign rs1_fwd_en = 1'b0;
    assign rs2_fwd_en = 1'b0;
    assign fwd_value  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed table-driven bench for writeback_unit (QDEPTH=2) plus hand-written reset sequences.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [31:0] alu_value;
    logic        alu_ready;
    logic        load_valid;
    logic [2:0]  load_rd;
    logic [31:0] load_value;
    logic        issue_valid;
    logic [2:0]  issue_rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rs1_fwd_en;
    logic        rs2_fwd_en;
    logic [31:0] fwd_value;
    logic        reg_write_en;
    logic [2:0]  rd;
    logic [31:0] rd_value;

    int errors = 0;
    int checks = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    writeback_unit #(.QDEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value), .alu_ready(alu_ready),
        .load_valid(load_valid), .load_rd(load_rd), .load_value(load_value),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd_en(rs1_fwd_en), .rs2_fwd_en(rs2_fwd_en), .fwd_value(fwd_value),
        .reg_write_en(reg_write_en), .rd(rd), .rd_value(rd_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [2:0]  lrd;
        logic [31:0] lval;
        logic        av;
        logic [2:0]  ard;
        logic [31:0] aval;
        logic        iv;
        logic [2:0]  ird;
        logic [2:0]  rs1;
        logic        e_rdy;
        logic        e_pend;
        logic        e_hit;
        logic        e_wen;
        logic [2:0]  e_rd;
        logic [31:0] e_val;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 3'd0; alu_value = 32'd0;
        load_valid = 1'b0; load_rd = 3'd0; load_value = 32'd0;
        issue_valid = 1'b0; issue_rd = 3'd0;
        rs1 = 3'd0; rs2 = 3'd0;
    endtask

    logic [31:0] cur_val;

    initial begin
        //            lv lrd  lval           av ard  aval           iv ird  rs1   rdy pend hit  wen rd   val
        vecs[0]  = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b0,3'd0,32'h0};
        vecs[1]  = '{1'b0,3'd0,32'h0,    1'b1,3'd3,32'h1234, 1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b1,3'd3,32'h1234};
        vecs[2]  = '{1'b1,3'd2,32'hAAAA, 1'b1,3'd5,32'h5555, 1'b0,3'd0,3'd3, 1'b1,1'b0,1'b1, 1'b1,3'd2,32'hAAAA};
        vecs[3]  = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd2, 1'b1,1'b0,1'b1, 1'b1,3'd5,32'h5555};
        vecs[4]  = '{1'b1,3'd1,32'h11,   1'b1,3'd6,32'h61,   1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b1,3'd1,32'h11};
        vecs[5]  = '{1'b1,3'd1,32'h12,   1'b1,3'd7,32'h71,   1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b1,3'd1,32'h12};
        vecs[6]  = '{1'b1,3'd1,32'h13,   1'b1,3'd6,32'h62,   1'b0,3'd0,3'd0, 1'b0,1'b0,1'b0, 1'b1,3'd1,32'h13};
        vecs[7]  = '{1'b1,3'd1,32'h14,   1'b1,3'd6,32'h62,   1'b0,3'd0,3'd0, 1'b0,1'b0,1'b0, 1'b1,3'd1,32'h14};
        vecs[8]  = '{1'b0,3'd0,32'h0,    1'b1,3'd6,32'h62,   1'b0,3'd0,3'd0, 1'b0,1'b0,1'b0, 1'b1,3'd6,32'h61};
        vecs[9]  = '{1'b0,3'd0,32'h0,    1'b1,3'd6,32'h62,   1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b1,3'd7,32'h71};
        vecs[10] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b1,3'd6,32'h62};
        vecs[11] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd6, 1'b1,1'b0,1'b1, 1'b0,3'd0,32'h0};
        vecs[12] = '{1'b0,3'd0,32'h0,    1'b1,3'd0,32'hFFFF, 1'b1,3'd0,3'd0, 1'b1,1'b0,1'b0, 1'b0,3'd0,32'h0};
        vecs[13] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b1,3'd4,3'd4, 1'b1,1'b0,1'b0, 1'b0,3'd0,32'h0};
        vecs[14] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd4, 1'b1,1'b1,1'b0, 1'b0,3'd0,32'h0};
        vecs[15] = '{1'b0,3'd0,32'h0,    1'b1,3'd4,32'h44,   1'b0,3'd0,3'd4, 1'b1,1'b1,1'b0, 1'b1,3'd4,32'h44};
        vecs[16] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd4, 1'b1,1'b0,1'b1, 1'b0,3'd0,32'h0};
        vecs[17] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd4, 1'b1,1'b0,1'b0, 1'b0,3'd0,32'h0};
        vecs[18] = '{1'b0,3'd0,32'h0,    1'b1,3'd6,32'h66,   1'b1,3'd6,3'd6, 1'b1,1'b0,1'b0, 1'b1,3'd6,32'h66};
        vecs[19] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd6, 1'b1,1'b1,1'b1, 1'b0,3'd0,32'h0};
        vecs[20] = '{1'b0,3'd0,32'h0,    1'b0,3'd0,32'h0,    1'b0,3'd0,3'd6, 1'b1,1'b1,1'b0, 1'b0,3'd0,32'h0};
        vecs[21] = '{1'b1,3'd0,32'h77,   1'b1,3'd2,32'h22,   1'b0,3'd0,3'd6, 1'b1,1'b1,1'b0, 1'b1,3'd2,32'h22};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wen", {31'd0, reg_write_en}, 32'd0);
        chk("reset_rd", {29'd0, rd}, 32'd0);
        chk("reset_val", rd_value, 32'd0);
        chk("reset_fwd1", {31'd0, rs1_fwd_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        cur_val = 32'd0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            load_valid = vecs[i].lv; load_rd = vecs[i].lrd; load_value = vecs[i].lval;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_value = vecs[i].aval;
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            rs1 = vecs[i].rs1; rs2 = 3'd0;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_rs1_busy", i), {31'd0, rs1_busy},
                {31'd0, BYP ? vecs[i].e_pend : (vecs[i].e_pend | vecs[i].e_hit)});
            chk($sformatf("v%0d_rs1_fwd", i), {31'd0, rs1_fwd_en}, {31'd0, BYP & vecs[i].e_hit});
            chk($sformatf("v%0d_fwd_val", i), fwd_value, BYP ? cur_val : 32'd0);
            chk($sformatf("v%0d_rs2_busy", i), {31'd0, rs2_busy}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", i), {31'd0, reg_write_en}, {31'd0, vecs[i].e_wen});
            chk($sformatf("v%0d_rd", i), {29'd0, rd}, {29'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_val", i), rd_value, vecs[i].e_val);
            cur_val = vecs[i].e_val;
        end

        // rs2 path: issue x5, then read it on rs2 while x6 is still pending on rs1.
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 3'd5;
        @(negedge clk);
        idle_inputs();
        rs2 = 3'd5; rs1 = 3'd6;
        #1;
        chk("rs2_pending", {31'd0, rs2_busy}, 32'd1);
        chk("rs1_x6_pending", {31'd0, rs1_busy}, 32'd1);

        // Fill the queue behind a load, then reset with two entries held.
        load_valid = 1'b1; load_rd = 3'd1; load_value = 32'h1;
        alu_valid = 1'b1; alu_rd = 3'd3; alu_value = 32'h33;
        @(negedge clk);
        load_value = 32'h2; alu_rd = 3'd5; alu_value = 32'h55;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("full_ready", {31'd0, alu_ready}, 32'd0);
        chk("full_wen", {31'd0, reg_write_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_wen", {31'd0, reg_write_en}, 32'd0);
        chk("midrst_rd", {29'd0, rd}, 32'd0);
        chk("midrst_val", rd_value, 32'd0);
        chk("midrst_ready", {31'd0, alu_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_wen%0d", k), {31'd0, reg_write_en}, 32'd0);
            chk($sformatf("post_rst_ready%0d", k), {31'd0, alu_ready}, 32'd1);
        end
        rs1 = 3'd6; rs2 = 3'd5;
        #1;
        chk("post_rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("post_rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter: QDEPTH, 2, ALU-result queue depth in entries (legal 1..4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: alu_valid  input  1, alu_rd  input  3, alu_value  input  32, which carry an ALU result offer.
REQ-005 SHALL have port: alu_ready  output  1  queue can accept an ALU result this cycle.
REQ-006 SHALL have ports: load_valid  input  1, load_rd  input  3, load_value  input  32, which carry a load completion (never stalled).
REQ-007 SHALL have ports: issue_valid  input  1, issue_rd  input  3, which mark an instruction issued that will write issue_rd.
REQ-008 SHALL have ports: rs1  input  3, rs2  input  3, which are source registers being read this cycle.
REQ-009 SHALL have ports: rs1_busy  output  1, rs2_busy  output  1, which mean the source value is not yet valid in the register file (or forward path).
REQ-010 SHALL have ports: rs1_fwd_en  output  1, rs2_fwd_en  output  1, fwd_value  output  32, which form the forward path.
REQ-011 SHALL have ports: reg_write_en  output  1, rd  output  3, rd_value  output  32, which drive the register-file write port, all registered.

Function
REQ-012 SHALL silently drop any ALU offer, load or issue with register index 0 (no queueing, no write, no pending bit); alu_ready is still honoured for ALU handshake.
REQ-013 SHALL accept an ALU result when alu_valid && alu_ready at a rising edge.
REQ-014 SHALL drive alu_ready = (queue count < QDEPTH), from registered count only (no same-cycle drain credit).
REQ-015 SHALL, each cycle, select the write source by priority: load_valid (rd!=0) first, else queue head, else the accepted ALU offer when queue empty, else none.
REQ-016 SHALL present the selected write on reg_write_en/rd/rd_value one cycle later (latency 1); reg_write_en=0 when nothing selected.
REQ-017 SHALL enqueue an accepted ALU result not selected that cycle; queue is FIFO, order preserved; simultaneous dequeue and enqueue keeps count unchanged.
REQ-018 SHALL keep an 8-bit pending vector: set bit issue_rd on issue_valid; clear bit rd at the edge a write to rd is registered onto the output.
REQ-019 SHALL let set win over clear when issue and write-registration hit the same register in the same cycle.
REQ-020 SHALL compute rsN_busy combinationally; index 0 never busy.
REQ-021 SHALL, with the load taking priority, hold a full queue (alu_ready=0) until at least one cycle without load_valid drains the head.

Reset
REQ-022 SHALL, while reset is high, force reg_write_en=0, rd=0, rd_value=0, queue empty (alu_ready=1 after release), pending=0, all fwd_en=0.
REQ-023 SHALL discard queued and in-flight results on reset mid-operation; no write issues after release until new input.

Configuration
REQ-024 SHALL provide macro WB_BYPASS_EN to compile the forward path in or out.
REQ-025 SHALL, without WB_BYPASS_EN, drive rsN_busy = pending[rsN] || (reg_write_en && rd==rsN), rsN_fwd_en=0, fwd_value=0.
REQ-026 SHALL, with WB_BYPASS_EN, drive rsN_busy = pending[rsN], rsN_fwd_en = reg_write_en && rd==rsN && rsN!=0, fwd_value = rd_value.

Verification
REQ-027 SHALL cover: reset, then alu_valid rd=3 value=32'h1234 with queue empty -> next cycle reg_write_en=1, rd=3, rd_value=32'h1234.
REQ-028 SHALL cover: load rd=2 value=32'hAAAA and ALU rd=5 value=32'h5555 same cycle -> cycle+1 writes x2, cycle+2 writes x5.
REQ-029 SHALL cover: load_valid held 4 cycles with ALU offers every cycle, QDEPTH=2 -> alu_ready low after 2 accepts, queued writes emerge in order after load drops.
REQ-030 SHALL cover: issue rd=4, then rs1=4 -> rs1_busy=1 until write to x4; during that write cycle rs1_busy=1 (no bypass) or rs1_fwd_en=1, fwd_value=write value (WB_BYPASS_EN).
REQ-031 SHALL cover: ALU and issue to rd=0 -> no write, rs1=0 never busy; issue rd=6 in same cycle as x6 write registers -> x6 stays pending.
REQ-032 SHALL cover: reset asserted with 2 queued entries -> outputs zero, no writes after release, alu_ready=1.
